// File: rtl/elevator_display_encoder.sv
// ---------------------------------------------------------------------------
// elevator_display_encoder
//
// Source end of the elevator 7-segment path. A snapshot of the elevator
// status (floor, travel direction, door state) is taken once per frame and
// shown across four time-multiplexed common-anode digits:
//   slot 0 : floor number (1..3), blank if the floor value is 0
//   slot 1 : direction arrow (up / down, blinking) or "-" when idle
//   slot 2 : "-" while the doors are open, blank otherwise
//   slot 3 : always blank
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   floor_in     current floor, 1..3 (0 is invalid and shown blank)
//   dir_in       00 idle, 01 up, 10 down, 11 invalid (shown as idle)
//   door_open    high while the doors are open
//   bin_out      4-bit display code for the binary-to-segment converter
//   anode_n      active-low digit enables, bit i drives digit slot i
//   frame_start  one-cycle pulse that marks the first output of a new frame
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLINK_FRAMES  frames per direction-blink period (even, >= 2)
// ---------------------------------------------------------------------------
module elevator_display_encoder #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] floor_in,
    input  logic [1:0] dir_in,
    input  logic       door_open,
    output logic [3:0] bin_out,
    output logic [3:0] anode_n,
    output logic       frame_start
);

    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_FRAMES);

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES / 2);

    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Display codes understood by the segment converter.
    localparam logic [3:0] CODE_UP      = 4'd4;
    localparam logic [3:0] CODE_DOWN    = 4'd8;
    localparam logic [3:0] CODE_NEUTRAL = 4'd12;
    localparam logic [3:0] CODE_BLANK   = 4'd0;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Counters
    logic [CNT_W-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [1:0]         slot_q,        slot_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;

    // Frame snapshot
    logic [1:0] snap_floor_q, snap_floor_d;
    logic [1:0] snap_dir_q,   snap_dir_d;
    logic       snap_door_q,  snap_door_d;

    // Registered outputs
    logic       snap_taken_q,  snap_taken_d;
    logic       frame_start_q, frame_start_d;
    logic [3:0] bin_q,         bin_d;
    logic [3:0] anode_n_q,     anode_n_d;

    logic slot_end;
    logic frame_end;
    logic blink_off;

    assign slot_end  = (refresh_cnt_q == CNT_MAX);
    assign frame_end = slot_end && (slot_q == 2'd3);
    assign blink_off = (blink_cnt_q >= BLINK_HALF);

    // -----------------------------------------------------------------------
    // Counter and snapshot next-state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        slot_d        = slot_q;
        blink_cnt_d   = blink_cnt_q;
        snap_floor_d  = snap_floor_q;
        snap_dir_d    = snap_dir_q;
        snap_door_d   = snap_door_q;

        if (slot_end) begin
            refresh_cnt_d = '0;
            slot_d        = slot_q + 2'd1;
        end

        // Inputs are sampled only here, so a frame is never torn by
        // mid-frame input changes.
        if (frame_end) begin
            snap_floor_d = floor_in;
            snap_dir_d   = dir_in;
            snap_door_d  = door_open;
            blink_cnt_d  = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + BLINK_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Slot decode from the snapshot; registered, so outputs trail the slot
    // and snapshot by one clock.
    // -----------------------------------------------------------------------
    always_comb begin
        bin_d     = CODE_BLANK;
        anode_n_d = ANODE_OFF;

        case (slot_q)
            2'd0: begin
                if (snap_floor_q != 2'd0) begin
                    bin_d     = {2'b00, snap_floor_q};
                    anode_n_d = 4'b1110;
                end
            end
            2'd1: begin
                case (snap_dir_q)
                    DIR_UP: begin
                        if (!blink_off) begin
                            bin_d     = CODE_UP;
                            anode_n_d = 4'b1101;
                        end
                    end
                    DIR_DOWN: begin
                        if (!blink_off) begin
                            bin_d     = CODE_DOWN;
                            anode_n_d = 4'b1101;
                        end
                    end
                    // Idle and the invalid 11 encoding both show a steady "-".
                    default: begin
                        bin_d     = CODE_NEUTRAL;
                        anode_n_d = 4'b1101;
                    end
                endcase
            end
            2'd2: begin
                if (snap_door_q) begin
                    bin_d     = CODE_NEUTRAL;
                    anode_n_d = 4'b1011;
                end
            end
            default: begin
                bin_d     = CODE_BLANK;
                anode_n_d = ANODE_OFF;
            end
        endcase

        // frame_start is delayed one extra clock so it lines up with the
        // first slot-0 output that uses the new snapshot.
        snap_taken_d  = frame_end;
        frame_start_d = snap_taken_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            slot_q        <= 2'd0;
            blink_cnt_q   <= '0;
            snap_floor_q  <= 2'd1;
            snap_dir_q    <= 2'b00;
            snap_door_q   <= 1'b0;
            snap_taken_q  <= 1'b0;
            frame_start_q <= 1'b0;
            bin_q         <= CODE_BLANK;
            anode_n_q     <= ANODE_OFF;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            refresh_cnt_q <= refresh_cnt_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            snap_floor_q  <= snap_floor_d;
            snap_dir_q    <= snap_dir_d;
            snap_door_q   <= snap_door_d;
            snap_taken_q  <= snap_taken_d;
            frame_start_q <= frame_start_d;
            bin_q         <= bin_d;
            anode_n_q     <= anode_n_d;
        end
    end

    assign bin_out     = bin_q;
    assign anode_n     = anode_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_elevator_display_encoder.sv
// ---------------------------------------------------------------------------
// tb_elevator_display_encoder
//
// Directed bench for elevator_display_encoder with REFRESH_DIV=4 and
// BLINK_FRAMES=4 (16-cycle frames). "Cycle n" is the state seen shortly
// after the n-th rising edge following reset release.
// ---------------------------------------------------------------------------
module tb_elevator_display_encoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] floor_in;
    logic [1:0] dir_in;
    logic       door_open;
    logic [3:0] bin_out;
    logic [3:0] anode_n;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    elevator_display_encoder #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .floor_in   (floor_in),
        .dir_in     (dir_in),
        .door_open  (door_open),
        .bin_out    (bin_out),
        .anode_n    (anode_n),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One frame of stimulus: inputs applied at the start of frame k, and the
    // hand-computed display of frame k (which shows the inputs of frame k-1).
    typedef struct packed {
        logic [1:0]       floor;
        logic [1:0]       dir;
        logic             door;
        logic [3:0][3:0]  code;   // code[s] = expected bin_out in slot s
        logic [3:0]       lit;    // lit[s]  = slot s anode expected low
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge. Anode exclusivity is
    // checked on every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        check("anode_onehot", ($countones(~anode_n) <= 1) ? 1 : 0, 1);
    endtask

    task automatic check_out(input string name, input logic [3:0] b,
                             input logic [3:0] a, input logic fs);
        check({name, "_bin"},   int'(bin_out),     int'(b));
        check({name, "_anode"}, int'(anode_n),     int'(a));
        check({name, "_fs"},    int'(frame_start), int'(fs));
    endtask

    function automatic vec_t mk(input logic [1:0] f, input logic [1:0] d,
                                input logic door, input logic [3:0] c0,
                                input logic [3:0] c1, input logic [3:0] c2,
                                input logic [3:0] c3, input logic [3:0] lit);
        vec_t v;
        v.floor   = f;
        v.dir     = d;
        v.door    = door;
        v.code[0] = c0;
        v.code[1] = c1;
        v.code[2] = c2;
        v.code[3] = c3;
        v.lit     = lit;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_an;
        int         s;

        //            inputs for frame k     expected display of frame k
        vecs[0]  = mk(2'd2, 2'b01, 1'b0,  4'd1, 4'd12, 4'd0,  4'd0, 4'b0011); // reset snapshot
        vecs[1]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd4,  4'd0,  4'd0, 4'b0011); // up, blink 1
        vecs[2]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd0,  4'd0,  4'd0, 4'b0001); // down, blink 2
        vecs[3]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd0,  4'd0,  4'd0, 4'b0001); // blink 3
        vecs[4]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd8,  4'd0,  4'd0, 4'b0011); // blink 0 (wrap)
        vecs[5]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd8,  4'd0,  4'd0, 4'b0011); // blink 1
        vecs[6]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd0,  4'd0,  4'd0, 4'b0001); // blink 2
        vecs[7]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd0,  4'd0,  4'd0, 4'b0001); // blink 3
        vecs[8]  = mk(2'd2, 2'b10, 1'b0,  4'd2, 4'd8,  4'd0,  4'd0, 4'b0011); // blink 0
        vecs[9]  = mk(2'd1, 2'b00, 1'b1,  4'd2, 4'd8,  4'd0,  4'd0, 4'b0011); // blink 1
        vecs[10] = mk(2'd1, 2'b11, 1'b1,  4'd1, 4'd12, 4'd12, 4'd0, 4'b0111); // idle, door, blink 2
        vecs[11] = mk(2'd0, 2'b00, 1'b0,  4'd1, 4'd12, 4'd12, 4'd0, 4'b0111); // dir 11, blink 3
        vecs[12] = mk(2'd3, 2'b00, 1'b0,  4'd0, 4'd12, 4'd0,  4'd0, 4'b0010); // floor 0 blank
        vecs[13] = mk(2'd3, 2'b00, 1'b0,  4'd3, 4'd12, 4'd0,  4'd0, 4'b0011); // floor 3 restored

        // ---- reset state -------------------------------------------------
        rst_n     = 1'b0;
        floor_in  = 2'd2;
        dir_in    = 2'b01;
        door_open = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 4'd0, 4'b1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven frames -----------------------------------------
        for (int k = 0; k < NVEC; k++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                if (c == 0) begin
                    floor_in  = vecs[k].floor;
                    dir_in    = vecs[k].dir;
                    door_open = vecs[k].door;
                end
                s      = c / 4;
                exp_an = vecs[k].lit[s] ? ~(4'b0001 << s) : 4'b1111;
                check_out($sformatf("f%0d_c%0d", k, c), vecs[k].code[s], exp_an,
                          (c == 0 && k > 0));
            end
        end

        // ---- no tearing: mid-frame floor change ------------------------
        // Frame 14 shows floor 3; floor 1 applied now is shown in frame 15.
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 0) floor_in = 2'd1;
            if (c < 4) check_out($sformatf("f14_c%0d", c), 4'd3, 4'b1110, (c == 0));
        end
        // Frame 15 shows floor 1; change to 3 at its cycle 5 must not appear
        // until the next frame.
        for (int c = 0; c < 16; c++) begin
            step();
            if (c < 4) check_out($sformatf("f15_c%0d", c), 4'd1, 4'b1110, (c == 0));
            if (c == 4) floor_in = 2'd3;
            if (c > 0) check($sformatf("f15_c%0d_fs", c), int'(frame_start), 0);
        end
        step();
        check_out("f16_c0", 4'd3, 4'b1110, 1'b1);

        // ---- asynchronous reset mid-slot 1 -------------------------------
        for (int c = 1; c < 6; c++) step();
        check_out("pre_rst_slot1", 4'd12, 4'b1101, 1'b0);
        floor_in  = 2'd2;
        dir_in    = 2'b01;
        door_open = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 4'd0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_held", 4'd0, 4'b1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 25; i++) begin
            step();
            case (i)
                1:  check_out("post_rst_c1",  4'd1,  4'b1110, 1'b0);
                5:  check_out("post_rst_c5",  4'd12, 4'b1101, 1'b0);
                9:  check_out("post_rst_c9",  4'd0,  4'b1111, 1'b0);
                16: check_out("post_rst_c16", 4'd0,  4'b1111, 1'b0);
                17: check_out("post_rst_c17", 4'd2,  4'b1110, 1'b1);
                21: check_out("post_rst_c21", 4'd4,  4'b1101, 1'b0);
                25: check_out("post_rst_c25", 4'd12, 4'b1011, 1'b0);
                default: ;
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
